// File: rtl/subkey_word_sequencer_if.sv
// Handshake and output bundle between the core control FSM (master) and the
// subkey word sequencer (slave).
//   start_i      : begin a schedule pass (honoured only while idle)
//   stall_i      : freeze the sequencer for this cycle
//   abort_i      : terminate the running pass without a done pulse
//   word_sel_o   : current key word index
//   subkey_idx_o : current subkey index s
//   word_valid_o : word_sel_o / control_o are meaningful
//   control_o    : one-hot {counter add, tweak1 add, tweak0 add}
//   tweak_sel0_o : s mod 3
//   tweak_sel1_o : (s+1) mod 3
//   last_word_o  : final word of the final subkey
//   busy_o       : pass in progress
//   done_o       : one-cycle completion pulse
interface subkey_word_sequencer_if #(
    parameter int IDX_W = 4,
    parameter int SK_W  = 5
);
    logic             start_i;
    logic             stall_i;
    logic             abort_i;
    logic [IDX_W-1:0] word_sel_o;
    logic [SK_W-1:0]  subkey_idx_o;
    logic             word_valid_o;
    logic [2:0]       control_o;
    logic [1:0]       tweak_sel0_o;
    logic [1:0]       tweak_sel1_o;
    logic             last_word_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, stall_i, abort_i,
        input  word_sel_o, subkey_idx_o, word_valid_o, control_o,
               tweak_sel0_o, tweak_sel1_o, last_word_o, busy_o, done_o
    );

    modport slave (
        input  start_i, stall_i, abort_i,
        output word_sel_o, subkey_idx_o, word_valid_o, control_o,
               tweak_sel0_o, tweak_sel1_o, last_word_o, busy_o, done_o
    );
endinterface

// File: rtl/subkey_word_sequencer.sv
// Registered subkey word sequencer for the Threefish key schedule. Walks the
// word index 0..NUM_WORDS-1 for every subkey s = 0..NUM_SUBKEYS-1, flags the
// two tweak words and the subkey-counter word with one-hot add controls, and
// produces the mod-3 tweak selects plus a start/busy/done handshake with stall
// and abort. Every output comes straight from a flop.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   seq   : slave side of subkey_word_sequencer_if (handshake and outputs)
module subkey_word_sequencer #(
    parameter int NUM_WORDS   = 16,
    parameter int NUM_SUBKEYS = 21,
    parameter int IDX_W       = 4,
    parameter int SK_W        = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    subkey_word_sequencer_if.slave  seq
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IDX_W-1:0] W_LAST = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] W_TW1  = IDX_W'(NUM_WORDS - 2);
    localparam logic [IDX_W-1:0] W_TW0  = IDX_W'(NUM_WORDS - 3);
    localparam logic [SK_W-1:0]  S_LAST = SK_W'(NUM_SUBKEYS - 1);

    state_t           state;
    logic [IDX_W-1:0] word_sel_q;
    logic [SK_W-1:0]  subkey_q;
    logic             valid_q;
    logic [2:0]       control_q;
    logic [1:0]       tsel0_q;
    logic [1:0]       tsel1_q;
    logic             last_q;
    logic             busy_q;
    logic             done_q;

    logic [IDX_W-1:0] word_inc;
    logic [SK_W-1:0]  subkey_inc;

    assign word_inc   = word_sel_q + IDX_W'(1);
    assign subkey_inc = subkey_q + SK_W'(1);

    // Controls are computed for the word index being loaded, so they line up
    // with word_sel_o in the same output cycle.
    function automatic logic [2:0] ctrl_for(input logic [IDX_W-1:0] w);
        if (w == W_TW0)       return 3'b001;
        else if (w == W_TW1)  return 3'b010;
        else if (w == W_LAST) return 3'b100;
        else                  return 3'b000;
    endfunction

    function automatic logic [1:0] next_mod3(input logic [1:0] t);
        return (t == 2'd2) ? 2'd0 : t + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || (state == RUN && seq.abort_i)) begin
            // Abort in RUN shares the reset image; it outranks stall and completion.
            state      <= IDLE;
            word_sel_q <= '0;
            subkey_q   <= '0;
            valid_q    <= 1'b0;
            control_q  <= '0;
            tsel0_q    <= 2'd0;
            tsel1_q    <= 2'd1;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (seq.start_i) begin
                        state      <= RUN;
                        word_sel_q <= '0;
                        subkey_q   <= '0;
                        valid_q    <= 1'b1;
                        control_q  <= ctrl_for('0);
                        tsel0_q    <= 2'd0;
                        tsel1_q    <= 2'd1;
                        last_q     <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (!seq.stall_i) begin
                        if (word_sel_q == W_LAST) begin
                            if (subkey_q == S_LAST) begin
                                // Completion: drop to the idle image with done raised.
                                state      <= DONE;
                                word_sel_q <= '0;
                                subkey_q   <= '0;
                                valid_q    <= 1'b0;
                                control_q  <= '0;
                                tsel0_q    <= 2'd0;
                                tsel1_q    <= 2'd1;
                                last_q     <= 1'b0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                            end else begin
                                // Word 0 of a subkey can never be the last word (NUM_WORDS >= 4).
                                word_sel_q <= '0;
                                subkey_q   <= subkey_inc;
                                control_q  <= ctrl_for('0);
                                tsel0_q    <= next_mod3(tsel0_q);
                                tsel1_q    <= next_mod3(tsel1_q);
                                last_q     <= 1'b0;
                            end
                        end else begin
                            word_sel_q <= word_inc;
                            control_q  <= ctrl_for(word_inc);
                            last_q     <= (word_inc == W_LAST) && (subkey_q == S_LAST);
                        end
                    end
                end
                DONE: begin
                    // start_i is deliberately ignored here.
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign seq.word_sel_o   = word_sel_q;
    assign seq.subkey_idx_o = subkey_q;
    assign seq.word_valid_o = valid_q;
    assign seq.control_o    = control_q;
    assign seq.tweak_sel0_o = tsel0_q;
    assign seq.tweak_sel1_o = tsel1_q;
    assign seq.last_word_o  = last_q;
    assign seq.busy_o       = busy_q;
    assign seq.done_o       = done_q;

endmodule

// File: tb/tb_subkey_word_sequencer.sv
// Self-checking bench for subkey_word_sequencer: a default instance (16 words,
// 21 subkeys) and a small instance (4 words, 19 subkeys). Outputs are packed as
// {word_sel[3:0], s[4:0], valid, control[2:0], tsel0[1:0], tsel1[1:0], last, busy, done}.
module tb_subkey_word_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic start, stall, abort;
    logic sel;                 // 0: default instance, 1: small instance
    logic [19:0] got;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    subkey_word_sequencer_if #(.IDX_W(4), .SK_W(5)) if16 ();
    subkey_word_sequencer_if #(.IDX_W(2), .SK_W(5)) if4 ();

    subkey_word_sequencer #(.NUM_WORDS(16), .NUM_SUBKEYS(21), .IDX_W(4), .SK_W(5)) u16 (
        .clk(clk), .rst_n(rst_n), .seq(if16)
    );
    subkey_word_sequencer #(.NUM_WORDS(4), .NUM_SUBKEYS(19), .IDX_W(2), .SK_W(5)) u4 (
        .clk(clk), .rst_n(rst_n), .seq(if4)
    );

    assign if16.start_i = start & ~sel;
    assign if16.stall_i = stall & ~sel;
    assign if16.abort_i = abort & ~sel;
    assign if4.start_i  = start & sel;
    assign if4.stall_i  = stall & sel;
    assign if4.abort_i  = abort & sel;

    always_comb begin
        if (sel)
            got = {2'b00, if4.word_sel_o, if4.subkey_idx_o, if4.word_valid_o, if4.control_o,
                   if4.tweak_sel0_o, if4.tweak_sel1_o, if4.last_word_o, if4.busy_o, if4.done_o};
        else
            got = {if16.word_sel_o, if16.subkey_idx_o, if16.word_valid_o, if16.control_o,
                   if16.tweak_sel0_o, if16.tweak_sel1_o, if16.last_word_o, if16.busy_o, if16.done_o};
    end

    function automatic logic [19:0] pk(int ws, int s, int v, int c, int t0, int t1,
                                       int l, int b, int d);
        return {4'(ws), 5'(s), 1'(v), 3'(c), 2'(t0), 2'(t1), 1'(l), 1'(b), 1'(d)};
    endfunction

    // Expected outputs while valid, from word/subkey position alone.
    function automatic logic [19:0] model(int nw, int ns, int w, int s);
        int c;
        c = (w == nw - 3) ? 1 : (w == nw - 2) ? 2 : (w == nw - 1) ? 4 : 0;
        return pk(w, s, 1, c, s % 3, (s + 1) % 3, (w == nw - 1 && s == ns - 1) ? 1 : 0, 1, 0);
    endfunction

    localparam logic [19:0] IDLE_IMG = 20'h00008;  // tsel1 = 1, all else 0
    localparam logic [19:0] DONE_IMG = 20'h00009;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        start;
        logic        stall;
        logic        abort;
        logic [19:0] exp;
    } vec_t;

    // One complete pass on the selected instance, optionally stalling at word
    // stall_w of subkey 0; checks every cycle plus aggregate counts.
    task automatic full_pass(input int nw, input int ns, input int stall_w,
                             input int stall_len, input int exp_done, input bit b2b);
        int n, w, s, cyc, vcount, lcount, multi, first_done;
        int hits[3];
        bit stalled;
        logic [19:0] e;
        n = 0; cyc = 1; vcount = 0; lcount = 0; multi = 0; first_done = -1; stalled = 0;
        hits[0] = 0; hits[1] = 0; hits[2] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (n < nw * ns) begin
            w = n % nw;
            s = n / nw;
            e = model(nw, ns, w, s);
            chk("pass", got, e);
            if (got[10]) vcount++;
            if (got[2]) lcount++;
            if (got[0] && first_done < 0) first_done = cyc;
            for (int b = 0; b < 3; b++) if (got[7 + b]) hits[b]++;
            if ($countones(got[9:7]) > 1) multi++;
            if (!stalled && w == stall_w && s == 0) begin
                stalled = 1'b1;
                stall = 1'b1;
                repeat (stall_len) begin
                    tick();
                    cyc++;
                    chk("stall_hold", got, e);
                end
                stall = 1'b0;
            end
            tick();
            cyc++;
            n++;
        end
        chk("done_pulse", got, DONE_IMG);
        if (got[0] && first_done < 0) first_done = cyc;
        chk_int("done_cycle", first_done, exp_done);
        chk_int("valid_cycles", vcount, nw * ns);
        chk_int("last_count", lcount, 1);
        chk_int("ctrl0_hits", hits[0], ns);
        chk_int("ctrl1_hits", hits[1], ns);
        chk_int("ctrl2_hits", hits[2], ns);
        chk_int("ctrl_multi", multi, 0);
        if (b2b) begin
            start = 1'b1;
            tick();
            chk("start_in_done_ignored", got, IDLE_IMG);
            tick();
            start = 1'b0;
            chk("start_after_done", got, model(nw, ns, 0, 0));
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_clean", got, IDLE_IMG);
        end else begin
            tick();
            chk("post_done_idle", got, IDLE_IMG);
        end
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, pk(0, 0, 1, 0, 0, 1, 0, 1, 0)};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, pk(1, 0, 1, 1, 0, 1, 0, 1, 0)};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, pk(1, 0, 1, 1, 0, 1, 0, 1, 0)};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, pk(2, 0, 1, 2, 0, 1, 0, 1, 0)};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, pk(3, 0, 1, 4, 0, 1, 0, 1, 0)};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, pk(3, 0, 1, 4, 0, 1, 0, 1, 0)};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, pk(0, 1, 1, 0, 1, 2, 0, 1, 0)};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, pk(1, 1, 1, 1, 1, 2, 0, 1, 0)};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, pk(2, 1, 1, 2, 1, 2, 0, 1, 0)};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, pk(3, 1, 1, 4, 1, 2, 0, 1, 0)};
        vecs[10] = '{1'b0, 1'b0, 1'b0, pk(0, 2, 1, 0, 2, 0, 0, 1, 0)};
        vecs[11] = '{1'b0, 1'b0, 1'b0, pk(1, 2, 1, 1, 2, 0, 0, 1, 0)};
        vecs[12] = '{1'b0, 1'b0, 1'b0, pk(2, 2, 1, 2, 2, 0, 0, 1, 0)};
        vecs[13] = '{1'b0, 1'b0, 1'b0, pk(3, 2, 1, 4, 2, 0, 0, 1, 0)};
        vecs[14] = '{1'b0, 1'b0, 1'b0, pk(0, 3, 1, 0, 0, 1, 0, 1, 0)};
        vecs[15] = '{1'b0, 1'b1, 1'b1, pk(0, 0, 0, 0, 0, 1, 0, 0, 0)};
        vecs[16] = '{1'b0, 1'b0, 1'b1, pk(0, 0, 0, 0, 0, 1, 0, 0, 0)};
        vecs[17] = '{1'b1, 1'b0, 1'b0, pk(0, 0, 1, 0, 0, 1, 0, 1, 0)};

        rst_n = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0; sel = 1'b0;
        repeat (3) tick();
        chk("reset16", got, IDLE_IMG);
        sel = 1'b1;
        #1;
        chk("reset4", got, IDLE_IMG);
        rst_n = 1'b1;
        tick();
        chk("idle4", got, IDLE_IMG);

        // Small instance: stepwise vectors covering start, stall, wrap, abort.
        for (int i = 0; i < 18; i++) begin
            start = vecs[i].start;
            stall = vecs[i].stall;
            abort = vecs[i].abort;
            tick();
            chk($sformatf("vec%0d", i), got, vecs[i].exp);
        end
        start = 1'b0; stall = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("vec_abort_cleanup", got, IDLE_IMG);

        full_pass(4, 19, -1, 0, 77, 1'b1);

        // Default instance.
        sel = 1'b0;
        tick();
        chk("idle16", got, IDLE_IMG);
        full_pass(16, 21, -1, 0, 337, 1'b0);

        // Reset held two cycles in the middle of a pass.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        chk("mid_run", got, model(16, 21, 39 % 16, 39 / 16));
        rst_n = 1'b0;
        tick();
        chk("reset_mid1", got, IDLE_IMG);
        tick();
        chk("reset_mid2", got, IDLE_IMG);
        rst_n = 1'b1;
        tick();
        chk("after_reset_no_done", got, IDLE_IMG);

        full_pass(16, 21, 15, 5, 342, 1'b0);

        // Abort at s = 7.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (112) tick();
        chk("pre_abort", got, model(16, 21, 0, 7));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", got, IDLE_IMG);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", got, IDLE_IMG);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
